// File: rtl/adc_spi_capture.sv
// adc_spi_capture: SPI front end for a 12-bit ADC with 16-clock frames.
// Ports: clk/rst (async, active-high); enable starts periodic conversions;
//   sdata from ADC; cs_n/sclk to ADC (CPOL=1); sample[11:0], data_valid
//   pulse and frame_err (non-zero leading nibble) to the downstream filter.
module adc_spi_capture #(
   parameter int CLK_DIV       = 4,
   parameter int SAMPLE_PERIOD = 1000,
   parameter int VALID_CYCLES  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        sdata,
   output logic        cs_n,
   output logic        sclk,
   output logic [11:0] sample,
   output logic        data_valid,
   output logic        frame_err
);

   localparam int TW   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int CMAX = (CLK_DIV > VALID_CYCLES) ? CLK_DIV : VALID_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [TW-1:0] T_LAST   = TW'(SAMPLE_PERIOD - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] VAL_LAST = CW'(VALID_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      LOAD,
      VALID
   } state_t;

   state_t        state, state_d;
   logic [TW-1:0] tcnt;
   logic [CW-1:0] cnt, cnt_d;
   logic [4:0]    bcnt, bcnt_d;
   logic [15:0]   sh, sh_d;
   logic          cs_n_d, sclk_d, dv_d, ferr_d;
   logic [11:0]   sample_d;
   logic          tick;

   assign tick = enable && (tcnt == '0);

   // Free-running sample-rate timer; parked at zero while disabled so the
   // first enabled cycle is always a start tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt <= '0;
      end else if (!enable) begin
         tcnt <= '0;
      end else if (tcnt == T_LAST) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         bcnt       <= '0;
         sh         <= '0;
         cs_n       <= 1'b1;
         sclk       <= 1'b1;
         sample     <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         bcnt       <= bcnt_d;
         sh         <= sh_d;
         cs_n       <= cs_n_d;
         sclk       <= sclk_d;
         sample     <= sample_d;
         data_valid <= dv_d;
         frame_err  <= ferr_d;
      end
   end

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      bcnt_d   = bcnt;
      sh_d     = sh;
      cs_n_d   = cs_n;
      sclk_d   = sclk;
      sample_d = sample;
      dv_d     = data_valid;
      ferr_d   = frame_err;
      unique case (state)
         IDLE: begin
            cs_n_d = 1'b1;
            sclk_d = 1'b1;
            cnt_d  = '0;
            bcnt_d = '0;
            if (tick) begin
               state_d = SETUP;
               cs_n_d  = 1'b0;
            end
         end
         SETUP: begin
            if (cnt == DIV_LAST) begin
               cnt_d   = '0;
               sclk_d  = 1'b0;
               state_d = SHIFT;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         SHIFT: begin
            // Each phase lasts CLK_DIV cycles. The low->high transition
            // captures sdata; the last high phase runs to completion so
            // every SCLK period keeps a 50% duty cycle.
            if (cnt == DIV_LAST) begin
               cnt_d = '0;
               if (!sclk) begin
                  sclk_d = 1'b1;
                  sh_d   = {sh[14:0], sdata};
                  bcnt_d = bcnt + 5'd1;
               end else if (bcnt == 5'd16) begin
                  state_d = LOAD;
               end else begin
                  sclk_d = 1'b0;
               end
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         LOAD: begin
            cs_n_d   = 1'b1;
            sample_d = sh[11:0];
            ferr_d   = |sh[15:12];
            cnt_d    = '0;
            state_d  = VALID;
         end
         VALID: begin
            // data_valid rises one cycle after sample moves, so the filter
            // always sees settled data on its clock edge.
            if (cnt == '0) begin
               dv_d  = 1'b1;
               cnt_d = cnt + 1'b1;
            end else if (cnt == VAL_LAST) begin
               dv_d    = 1'b0;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_adc_spi_capture.sv
// tb_adc_spi_capture: self-checking bench for adc_spi_capture with a
// behavioural ADC model and a frame-level reference of expected results.
module tb_adc_spi_capture;

   localparam int D  = 4;
   localparam int P  = 1000;
   localparam int VC = 2;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        sdata;
   logic        cs_n;
   logic        sclk;
   logic [11:0] sample;
   logic        data_valid;
   logic        frame_err;

   adc_spi_capture #(
      .CLK_DIV      (D),
      .SAMPLE_PERIOD(P),
      .VALID_CYCLES (VC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .sdata     (sdata),
      .cs_n      (cs_n),
      .sclk      (sclk),
      .sample    (sample),
      .data_valid(data_valid),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] adc_q[$];
   logic [15:0] exp_q[$];

   logic        dv_q;
   logic [11:0] samp_q;

   int j_csfall, n_csfall, j_sfall, n_rise, per_bad, idle_bad;
   int cs_low, j_samp, j_dv, n_dv;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [15:0] w);
      adc_q.push_back(w);
      exp_q.push_back(w);
   endtask

   // ADC model: word chosen at CS fall, one bit MSB-first per SCLK fall.
   initial begin
      logic [15:0] w;
      int idx;
      sdata = 1'b0;
      forever begin
         @(negedge cs_n);
         w   = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0000;
         idx = 15;
         forever begin
            @(negedge sclk or posedge cs_n);
            if (cs_n) break;
            if (idx >= 0) begin
               sdata = w[idx];
               idx--;
            end
         end
      end
   end

   // One clock cycle; checks every data_valid pulse against the reference.
   task automatic step();
      logic [15:0] w;
      @(posedge clk);
      @(negedge clk);
      if (data_valid && !dv_q) begin
         if (exp_q.size() == 0) begin
            chk("dv_spurious", 32'(1), 32'(0));
         end else begin
            w = exp_q.pop_front();
            chk("sample", 32'(sample), 32'(w[11:0]));
            chk("frame_err", 32'(frame_err), 32'(w[15:12] != 4'h0));
         end
         chk("hold_pre", 32'(sample), 32'(samp_q));
      end else if (data_valid) begin
         chk("hold_dv", 32'(sample), 32'(samp_q));
      end
      dv_q   = data_valid;
      samp_q = sample;
   endtask

   // Observe n cycles; j counts clk edges from the start tick (j=0).
   task automatic watch(input int n, input int drop_at);
      logic pcs, psclk;
      logic [11:0] psamp;
      int last_rise;
      j_csfall = -1; n_csfall = 0; j_sfall = -1; n_rise = 0;
      per_bad = 0; idle_bad = 0; cs_low = 0; j_samp = -1;
      j_dv = -1; n_dv = 0; last_rise = -1;
      pcs = cs_n; psclk = sclk; psamp = sample;
      for (int j = 0; j < n; j++) begin
         step();
         if (pcs && !cs_n) begin
            n_csfall++;
            if (j_csfall < 0) j_csfall = j;
         end
         if (!cs_n) cs_low++;
         if (!cs_n && psclk && !sclk && j_sfall < 0) j_sfall = j;
         if (!cs_n && !psclk && sclk) begin
            n_rise++;
            if (last_rise >= 0 && j - last_rise != 2 * D) per_bad++;
            last_rise = j;
         end
         if (cs_n && !sclk) idle_bad++;
         if (sample != psamp && j_samp < 0) j_samp = j;
         if (data_valid) begin
            n_dv++;
            if (j_dv < 0) j_dv = j;
         end
         pcs = cs_n; psclk = sclk; psamp = sample;
         if (j == drop_at) enable = 1'b0;
      end
   endtask

   task automatic frame_checks(input string tag);
      chk({tag, "_cs_fall"}, 32'(j_csfall), 32'(0));
      chk({tag, "_n_frames"}, 32'(n_csfall), 32'(1));
      chk({tag, "_sclk_fall1"}, 32'(j_sfall), 32'(D));
      chk({tag, "_n_rise"}, 32'(n_rise), 32'(16));
      chk({tag, "_sclk_period"}, 32'(per_bad), 32'(0));
      chk({tag, "_sclk_idle"}, 32'(idle_bad), 32'(0));
      chk({tag, "_cs_low"}, 32'(cs_low), 32'(33 * D + 1));
      chk({tag, "_dv_rise"}, 32'(j_dv), 32'(33 * D + 2));
      chk({tag, "_dv_width"}, 32'(n_dv), 32'(VC));
   endtask

   initial begin
      logic [15:0] w;
      rst    = 1'b1;
      enable = 1'b0;
      dv_q   = 1'b0;
      samp_q = '0;
      repeat (3) @(negedge clk);
      chk("rst_cs_n", 32'(cs_n), 32'(1));
      chk("rst_sclk", 32'(sclk), 32'(1));
      chk("rst_sample", 32'(sample), 32'(0));
      chk("rst_dv", 32'(data_valid), 32'(0));
      chk("rst_ferr", 32'(frame_err), 32'(0));
      rst = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("idle_cs_n", 32'(cs_n), 32'(1));

      // Single conversion.
      push(16'h0ABC);
      enable = 1'b1;
      watch(140, -1);
      frame_checks("single");
      chk("single_samp_time", 32'(j_samp), 32'(33 * D + 1));
      enable = 1'b0;
      for (int i = 0; i < 10; i++) step();

      // Frame error followed by a clean frame one period later.
      push(16'hF123);
      push(16'h0001);
      enable = 1'b1;
      watch(P, -1);
      frame_checks("ferr1");
      watch(140, -1);
      frame_checks("ferr2");
      enable = 1'b0;
      for (int i = 0; i < 10; i++) step();

      // Periodic capture of incrementing values.
      for (int i = 1; i <= 5; i++) push(16'(i));
      enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         watch(P, -1);
         frame_checks("periodic");
      end
      enable = 1'b0;
      for (int i = 0; i < 10; i++) step();

      // Random frames, some with a non-zero leading nibble.
      for (int i = 0; i < 6; i++) begin
         w = 16'($urandom_range(0, 65535));
         if ($urandom_range(0, 1) == 0) w[15:12] = 4'h0;
         push(w);
      end
      enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         watch(P, -1);
         frame_checks("random");
      end
      enable = 1'b0;
      for (int i = 0; i < 10; i++) step();

      // Enable dropped mid-SHIFT: frame completes, nothing follows.
      push(16'hA555);
      enable = 1'b1;
      watch(2500, 60);
      frame_checks("drop");
      chk("drop_cs_idle", 32'(cs_n), 32'(1));

      // Asynchronous reset mid-frame, away from any clock edge.
      push(16'h0777);
      enable = 1'b1;
      for (int i = 0; i < 50; i++) step();
      #2 rst = 1'b1;
      #1;
      chk("arst_cs_n", 32'(cs_n), 32'(1));
      chk("arst_sclk", 32'(sclk), 32'(1));
      chk("arst_sample", 32'(sample), 32'(0));
      chk("arst_dv", 32'(data_valid), 32'(0));
      chk("arst_ferr", 32'(frame_err), 32'(0));
      #1 rst = 1'b0;
      void'(exp_q.pop_front());
      push(16'h0C3A);
      watch(140, -1);
      frame_checks("after_rst");
      chk("after_rst_samp_time", 32'(j_samp), 32'(33 * D + 1));
      enable = 1'b0;
      for (int i = 0; i < 10; i++) step();

      chk("exp_drained", 32'(exp_q.size()), 32'(0));
      chk("adc_drained", 32'(adc_q.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
